serial_to_parallel_loader: RTL

//   Assembles a serial bit stream into BIT_OF_DATA-wide words and presents each completed

---
 rtl/s2p_pkg.sv | 19 +
 rtl/s2p_gap_timer.sv | 31 +++
 rtl/serial_to_parallel_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and width helpers for the serial-to-parallel loader.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } s2p_state_t;

    function automatic int bit_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int gap_cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/s2p_gap_timer.sv
// Inter-bit gap timer: counts idle cycles inside a frame and flags expiry
// combinationally on the TIMEOUT_CYCLES-th consecutive idle cycle.
module s2p_gap_timer
    import s2p_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int GAP_W = gap_cnt_w(TIMEOUT_CYCLES);

    logic [GAP_W-1:0] cnt;

    assign expire = count && (cnt == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_to_parallel_loader.sv
// Assembles a serial bit stream into words with frame start, gap timeout and restart.
// Optional trailing even-parity bit is enabled by defining S2P_PARITY_EN.
module serial_to_parallel_loader
    import s2p_pkg::*;
#(
    parameter int BIT_OF_DATA    = 8,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    output logic [BIT_OF_DATA-1:0] data_out,
    output logic                   load_data,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   parity_err
);

    localparam int CNT_W = bit_cnt_w(BIT_OF_DATA);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_OF_DATA - 1);

    s2p_state_t             state;
    logic [BIT_OF_DATA-1:0] shreg;
    logic [BIT_OF_DATA-1:0] shifted;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   in_frame;
    logic                   gap_expire;

    assign in_frame = (state == SHIFT) || (state == PARITY);
    assign busy     = (state != IDLE);

    always_comb begin
        shifted = shreg;
        if (MSB_FIRST != 0) shifted = {shreg[BIT_OF_DATA-2:0], bit_in};
        else                shifted = {bit_in, shreg[BIT_OF_DATA-1:1]};
    end

    // A restart or an accepted bit both restart the gap measurement.
    s2p_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_frame || frame_start || bit_valid),
        .count (in_frame && !frame_start && !bit_valid),
        .expire(gap_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            load_data  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            load_data  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            // frame_start takes priority over timeout; it only counts as an error mid-frame.
            if (frame_start) begin
                if (in_frame) frame_err <= 1'b1;
                state   <= SHIFT;
                bit_cnt <= bit_valid ? CNT_W'(1) : '0;
                if (bit_valid) shreg <= shifted;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    DONE: state <= IDLE;
                    SHIFT: begin
                        if (gap_expire) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (bit_valid) begin
                            shreg <= shifted;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
`ifdef S2P_PARITY_EN
                                state   <= PARITY;
`else
                                state     <= DONE;
                                data_out  <= shifted;
                                load_data <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (gap_expire) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (bit_valid) begin
`ifdef S2P_PARITY_EN
                            state <= DONE;
                            if ((^shreg ^ bit_in) == 1'b0) begin
                                data_out  <= shreg;
                                load_data <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
